three_phase_lut_sequencer: RTL and testbench

Time-multiplexed scheduler that shares one single-port sine LUT (`N_SAMPLES` entries, registered read) between three phase channels. On each sample strobe it issues three LUT reads at base, base+120° and base+240°, then updates all three modulating-wave outputs in the same clock. Between strobes it advances the common phase base by a programmable step. It sits between the sample-rate tick source and the SPWM comparators, replacing three per-phase LUT copies.

---
 rtl/three_phase_lut_sequencer_if.sv | 46 ++++
 rtl/three_phase_lut_sequencer.sv | 151 +++++++++++++++
 tb/tb_three_phase_lut_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/three_phase_lut_sequencer_if.sv
// three_phase_lut_sequencer_if
// Bundles the tick/step control, the shared sine-LUT read bus and the three
// phase outputs of the LUT sequencer into one interface.
//
// Signals:
//   en, tick, step        control from the sample-rate tick source
//   lut_rd, lut_addr      read request to the single-port sine LUT
//   lut_data              LUT output, one cycle after the read request
//   out_a, out_b, out_c   phase samples towards the SPWM comparators
//   out_valid             one-cycle pulse: new phase samples present
//   busy, tick_miss       sequencer status
//   cfg_err               one-cycle pulse: out-of-range step was used
//
// Modports:
//   master  the sequencer side (drives LUT bus and phase outputs)
//   slave   the environment side (tick source, LUT, comparators)
interface three_phase_lut_sequencer_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              en;
    logic              tick;
    logic [ADDR_W-1:0] step;
    logic              lut_rd;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-1:0] lut_data;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_c;
    logic              out_valid;
    logic              busy;
    logic              tick_miss;
    logic              cfg_err;

    modport master (
        input  en, tick, step, lut_data,
        output lut_rd, lut_addr, out_a, out_b, out_c,
               out_valid, busy, tick_miss, cfg_err
    );

    modport slave (
        output en, tick, step, lut_data,
        input  lut_rd, lut_addr, out_a, out_b, out_c,
               out_valid, busy, tick_miss, cfg_err
    );
endinterface

// File: rtl/three_phase_lut_sequencer.sv
// three_phase_lut_sequencer
// Shares one single-port sine LUT (registered read) between three phase
// channels. Each accepted tick issues three reads at base, base+1/3 period
// and base+2/3 period, then updates all three phase outputs together and
// advances the common phase base by the step sampled with the tick.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    three_phase_lut_sequencer_if.master
//            in : en, tick, step, lut_data
//            out: lut_rd, lut_addr, out_a/b/c, out_valid, busy,
//                 tick_miss, cfg_err
module three_phase_lut_sequencer #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int N_SAMPLES = 20000,
    parameter int PH_OFF_B  = 6666,
    parameter int PH_OFF_C  = 13333
) (
    input  logic                              clk,
    input  logic                              rst_n,
    three_phase_lut_sequencer_if.master       bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] RD_C = 3'd3;
    localparam logic [2:0] LOAD = 3'd4;

    localparam logic [ADDR_W:0]   N_EXT = (ADDR_W+1)'(N_SAMPLES);
    localparam logic [ADDR_W-1:0] OFF_B = ADDR_W'(PH_OFF_B);
    localparam logic [ADDR_W-1:0] OFF_C = ADDR_W'(PH_OFF_C);

    logic [2:0]        state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] step_q;
    logic [DATA_W-1:0] shadow_a;
    logic [DATA_W-1:0] shadow_b;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [DATA_W-1:0] out_c_q;
    logic              lut_rd_q;
    logic [ADDR_W-1:0] lut_addr_q;
    logic              out_valid_q;
    logic              tick_miss_q;
    logic              cfg_err_q;

    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] base_next;
    logic              step_bad;

    // Both operands are below N_SAMPLES, so a single conditional subtraction
    // brings the ADDR_W+1-bit sum back into range.
    function automatic logic [ADDR_W-1:0] wrap_add(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b
    );
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        return sum[ADDR_W-1:0];
    endfunction

    assign addr_b    = wrap_add(base, OFF_B);
    assign addr_c    = wrap_add(base, OFF_C);
    assign base_next = wrap_add(base, step_q);
    assign step_bad  = ({1'b0, step_q} >= N_EXT);

    // Sequencer: the LUT answers one cycle after each read, so each read
    // state captures the sample requested by the previous one, and the
    // last sample (phase C) is taken straight from lut_data in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            step_q      <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            lut_rd_q    <= 1'b0;
            lut_addr_q  <= '0;
            out_valid_q <= 1'b0;
            tick_miss_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            tick_miss_q <= bus.tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.tick && bus.en) begin
                        step_q     <= bus.step;
                        lut_rd_q   <= 1'b1;
                        lut_addr_q <= base;
                        state      <= RD_A;
                    end
                end
                RD_A: begin
                    lut_addr_q <= addr_b;
                    state      <= RD_B;
                end
                RD_B: begin
                    shadow_a   <= bus.lut_data;
                    lut_addr_q <= addr_c;
                    state      <= RD_C;
                end
                RD_C: begin
                    shadow_b <= bus.lut_data;
                    lut_rd_q <= 1'b0;
                    state    <= LOAD;
                end
                LOAD: begin
                    out_a_q     <= shadow_a;
                    out_b_q     <= shadow_b;
                    out_c_q     <= bus.lut_data;
                    out_valid_q <= 1'b1;
                    // An out-of-range step freezes the base instead of
                    // letting it escape the table.
                    if (step_bad) begin
                        cfg_err_q <= 1'b1;
                    end else begin
                        base <= base_next;
                    end
                    state <= IDLE;
                end
                default: begin
                    lut_rd_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.lut_rd    = lut_rd_q;
    assign bus.lut_addr  = lut_addr_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state != IDLE);
    assign bus.tick_miss = tick_miss_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_three_phase_lut_sequencer.sv
// tb_three_phase_lut_sequencer
// Drives three_phase_lut_sequencer with directed and randomized ticks while a
// behavioural model tracks the phase base with modulo arithmetic and looks up
// the expected samples in the bench-owned sine LUT contents.
module tb_three_phase_lut_sequencer;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int N      = 20000;
    localparam int OFF_B  = 6666;
    localparam int OFF_C  = 13333;

    logic clk;
    logic rst_n;

    three_phase_lut_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    three_phase_lut_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SAMPLES(N),
        .PH_OFF_B(OFF_B), .PH_OFF_C(OFF_C)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DATA_W-1:0] lut_mem [0:N-1];

    int checks = 0;
    int errors = 0;
    int base_m = 0;
    int exp_a  = 0;
    int exp_b  = 0;
    int exp_c  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read LUT: data for a read appears on the next cycle.
    always @(posedge clk) begin
        if (bus.lut_rd) begin
            bus.lut_data <= lut_mem[int'(bus.lut_addr)];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic e, input int s);
        bus.tick = t;
        bus.en   = e;
        bus.step = ADDR_W'(s);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".busy"},      32'(bus.busy),      0);
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 0);
        checkOutput({tag, ".lut_rd"},    32'(bus.lut_rd),    0);
        checkOutput({tag, ".out_a"},     32'(bus.out_a),     exp_a);
        checkOutput({tag, ".out_c"},     32'(bus.out_c),     exp_c);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            checkQuiet("idle");
            checkOutput("idle.tick_miss", 32'(bus.tick_miss), 0);
        end
    endtask

    // One accepted tick, checked cycle by cycle against the model.
    // miss_at (1..4, 0 = none) is the busy cycle carrying an extra tick.
    task automatic runSequence(input int s, input int miss_at, input bit drop_en);
        int  a_addr, b_addr, c_addr;
        bit  bad;
        string tg;
        a_addr = base_m;
        b_addr = (base_m + OFF_B) % N;
        c_addr = (base_m + OFF_C) % N;
        bad    = (s >= N);
        applyStimulus(1'b1, 1'b1, s);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            applyStimulus(cyc == miss_at, !drop_en, s);
            tg = $sformatf("base%0d.c%0d", base_m, cyc);
            checkOutput({tg, ".lut_rd"},    32'(bus.lut_rd),    32'(cyc <= 3));
            checkOutput({tg, ".busy"},      32'(bus.busy),      32'(cyc <= 4));
            checkOutput({tg, ".out_valid"}, 32'(bus.out_valid), 32'(cyc == 5));
            checkOutput({tg, ".cfg_err"},   32'(bus.cfg_err),   32'(cyc == 5 && bad));
            checkOutput({tg, ".tick_miss"}, 32'(bus.tick_miss),
                        32'(miss_at != 0 && cyc == miss_at + 1));
            checkOutput({tg, ".lut_addr"},  32'(bus.lut_addr),
                        (cyc == 1) ? a_addr : (cyc == 2) ? b_addr : c_addr);
            if (cyc == 5) begin
                exp_a = lut_mem[a_addr];
                exp_b = lut_mem[b_addr];
                exp_c = lut_mem[c_addr];
            end
            checkOutput({tg, ".out_a"}, 32'(bus.out_a), exp_a);
            checkOutput({tg, ".out_b"}, 32'(bus.out_b), exp_b);
            checkOutput({tg, ".out_c"}, 32'(bus.out_c), exp_c);
        end
        if (!bad) begin
            base_m = (base_m + s) % N;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            lut_mem[i] = DATA_W'($urandom);
        end
        bus.lut_data = '0;
        applyStimulus(1'b0, 1'b0, 0);

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkQuiet("reset");
        checkOutput("reset.lut_addr",  32'(bus.lut_addr),  0);
        checkOutput("reset.tick_miss", 32'(bus.tick_miss), 0);
        checkOutput("reset.cfg_err",   32'(bus.cfg_err),   0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycles(2);

        // Tick with en low is ignored without a miss pulse
        applyStimulus(1'b1, 1'b0, 5);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 5);
        checkQuiet("en_low");
        idleCycles(1);

        // Single sample with step 1, then a back-to-back tick in cycle 5
        runSequence(1, 0, 1'b0);
        runSequence(19998, 0, 1'b0);

        // Base now 19999: wrap-around and the sequence after it
        runSequence(1, 0, 1'b0);
        runSequence(1, 0, 1'b0);
        idleCycles(1);

        // Overrun: second tick two cycles after the accepted one
        runSequence(3, 2, 1'b0);
        idleCycles(1);

        // Bad step at base 5, then step 0 re-reads the same base
        runSequence((5 - base_m + N) % N, 0, 1'b0);
        runSequence(N, 0, 1'b0);
        runSequence(0, 0, 1'b1);
        idleCycles(2);

        // Reset pulled low in cycle 2 of a sequence
        applyStimulus(1'b1, 1'b1, 7);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        base_m = 0;
        exp_a = 0;
        exp_b = 0;
        exp_c = 0;
        checkQuiet("midrst");
        checkOutput("midrst.out_b", 32'(bus.out_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idleCycles(4);
        runSequence(2, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            int s;
            int miss;
            bit de;
            s    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(N, 32767))
                                               : int'($urandom_range(0, N - 1));
            miss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            de   = 1'($urandom_range(0, 1));
            runSequence(s, miss, de);
            idleCycles(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
